stream_arbiter: RTL and testbench
=================================

STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter SDW, default 32, sample data width.
REQ-002 Parameter NCH, default 4, number of input streams (2..16).
REQ-003 Parameter BURST, default 4, maximum consecutive transfers granted to one channel (1..256).
REQ-004 Port clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port ena  input  NCH  per-channel enable mask; a channel with ena[i]=0 SHALL never be granted.
REQ-007 Port sti_tvalid  input  NCH  per-channel valid.
REQ-008 Port sti_tready  output  NCH  per-channel ready.
REQ-009 Port sti_tdata  input  NCH*SDW  channel i occupies bits [i*SDW +: SDW].
REQ-010 Port sto_tready  input  1  output stream ready.
REQ-011 Port sto_tvalid  output  1  output stream valid, registered.
REQ-012 Port sto_tdata  output  SDW  output sample, registered.
REQ-013 Port sto_tid  output  clog2(NCH)  source channel of sto_tdata, registered.

Function
REQ-014 Internal ready rdy SHALL equal sto_tready | ~sto_tvalid; no combinational path from any sti_tvalid to any sti_tready.
REQ-015 A transfer on channel i occurs when sti_tvalid[i] & sti_tready[i]; at most one sti_tready bit SHALL be high per cycle.
REQ-016 The FSM SHALL have two states: IDLE (no owner) and LOCK (owner register gnt holds the channel).
REQ-017 IDLE: sel = first i with sti_tvalid[i] & ena[i], searching cyclically from ptr upward; sti_tready[sel] = rdy; no candidate -> all sti_tready low.
REQ-018 IDLE with a transfer: gnt <= sel, cnt <= 1; go to LOCK if BURST>1, else stay IDLE with ptr <= sel+1 mod NCH.
REQ-019 LOCK: sti_tready[gnt] = rdy & ena[gnt]; all other readys low.
REQ-020 LOCK transfer: cnt <= cnt+1; if cnt+1 == BURST, go IDLE with ptr <= gnt+1 mod NCH.
REQ-021 LOCK release without transfer: when sti_tvalid[gnt]=0 or ena[gnt]=0, go IDLE next cycle with ptr <= gnt+1 mod NCH; an enable drop SHALL block transfer in that same cycle.
REQ-022 LOCK with rdy=0 and sti_tvalid[gnt]=1 SHALL hold state, cnt and gnt unchanged (backpressure does not consume burst budget).
REQ-023 On any transfer, sto_tdata <= selected channel data and sto_tid <= channel index next cycle; latency exactly 1 cycle.
REQ-024 sto_tvalid: when rdy=1, load 1 on a transfer, else 0; when rdy=0, hold; sto_tdata/sto_tid SHALL hold while sto_tvalid & ~sto_tready.
REQ-025 Counter cnt SHALL be clog2(BURST+1) bits and never exceed BURST; ptr SHALL wrap NCH-1 -> 0.
REQ-026 With NCH continuously valid, enabled channels, grants SHALL rotate 0,1,..,NCH-1,0 in blocks of BURST transfers with no idle output cycle between blocks when sto_tready=1 (IDLE selection is same-cycle).

Reset
REQ-027 While rst=0: sto_tvalid=0, sto_tdata=0, sto_tid=0, state=IDLE, gnt=0, ptr=0, cnt=0, all sti_tready=0.
REQ-028 Reset asserted mid-burst SHALL discard the pending output sample; after release arbitration SHALL restart from channel 0.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (IDLE, LOCK) and the clog2 width constants function.
REQ-030 The cyclic first-one search SHALL be one combinational sub-module arb_rr_pick (inputs req, ptr; outputs sel, any).

Verification
REQ-031 NCH=4, BURST=4, all valid/enabled, sto_tready=1 -> sto_tid sequence 0x4,1x4,2x4,3x4,0..., sto_tvalid continuously 1.
REQ-032 Only ch2 valid, data 0xA5A5_0001.. -> output same data, tid=2, 1-cycle latency; release after 4, immediate regrant to ch2.
REQ-033 Ch1 owner, sto_tready low 5 cycles after 2nd transfer -> output held stable, cnt stays 2, ch1 completes exactly 4 transfers.
REQ-034 Ch0 owner, ena[0] dropped after 1 transfer, ch3 valid -> no ch0 transfer that cycle, next grant ch3 (ptr=1, ch1/ch2 idle).
REQ-035 rst asserted while sto_tvalid=1 in LOCK -> all outputs 0 asynchronously; after release first grant goes to lowest valid channel from 0.
REQ-036 BURST=1, ch0 and ch1 valid -> strict alternation 0,1,0,1 every cycle.

Source files
------------

// File: rtl/stream_arbiter_pkg.sv
// stream_arbiter_pkg: FSM state type and width helper shared by the stream arbiter files
package stream_arbiter_pkg;
  typedef enum logic {IDLE, LOCK} state_e;
  function automatic int clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_arbiter_arb_rr_pick.sv
// arb_rr_pick: cyclic first-one search over req starting at ptr
// Ports: req (candidate mask), ptr (search start), sel (first set index at/after ptr), any (req nonzero)
module arb_rr_pick
  import stream_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  localparam int IW = clog2w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [IW-1:0]  sel,
  output logic           any
);
  // Scanning from the farthest offset down lets the nearest hit overwrite the others.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NCH]) begin
        sel = IW'((int'(ptr) + i) % NCH);
        any = 1'b1;
      end
  end
endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin burst arbiter merging NCH valid/ready streams into one registered stream
// Ports: clk, rst (async active-low), ena (grant mask), sti_* (NCH inputs, data packed i*SDW),
//        sto_* (merged output with source id)
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int SDW = 32,
  parameter int NCH = 4,
  parameter int BURST = 4,
  localparam int IW = clog2w(NCH),
  localparam int CW = clog2w(BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ena,
  input  logic [NCH-1:0]     sti_tvalid,
  output logic [NCH-1:0]     sti_tready,
  input  logic [NCH*SDW-1:0] sti_tdata,
  input  logic               sto_tready,
  output logic               sto_tvalid,
  output logic [SDW-1:0]     sto_tdata,
  output logic [IW-1:0]      sto_tid
);
  state_e state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sto_tid_q, sto_tid_d, sel, xch;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sto_tvalid_q, sto_tvalid_d;
  logic [SDW-1:0] sto_tdata_q, sto_tdata_d;
  logic rdy, any, xfer, last;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] c);
    return (c == IW'(NCH - 1)) ? '0 : c + 1'b1;
  endfunction
  arb_rr_pick #(.NCH(NCH)) u_pick (
    .req(sti_tvalid & ena),
    .ptr(ptr_q),
    .sel(sel),
    .any(any)
  );
  assign rdy = sto_tready | ~sto_tvalid_q;
  // Readys are gated by rst so nothing handshakes while reset is held.
  always_comb begin
    xch = (state_q == IDLE) ? sel : gnt_q;
    sti_tready = '0;
    sti_tready[xch] = rst & rdy & ((state_q == IDLE) ? any : ena[gnt_q]);
    xfer = |(sti_tvalid & sti_tready);
    last = (cnt_q + 1'b1) == CW'(BURST);
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (xfer) begin
        gnt_d = sel;
        cnt_d = CW'(1);
        state_d = (BURST > 1) ? LOCK : IDLE;
        ptr_d = (BURST > 1) ? ptr_q : nxt(sel);
      end
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      state_d = last ? IDLE : LOCK;
      ptr_d = last ? nxt(gnt_q) : ptr_q;
    end else if (!sti_tvalid[gnt_q] || !ena[gnt_q]) begin
      state_d = IDLE;
      ptr_d = nxt(gnt_q);
    end
    sto_tvalid_d = rdy ? xfer : sto_tvalid_q;
    sto_tdata_d = xfer ? sti_tdata[int'(xch)*SDW +: SDW] : sto_tdata_q;
    sto_tid_d = xfer ? xch : sto_tid_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      sto_tvalid_q <= 1'b0;
      sto_tdata_q <= '0;
      sto_tid_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      sto_tvalid_q <= sto_tvalid_d;
      sto_tdata_q <= sto_tdata_d;
      sto_tid_q <= sto_tid_d;
    end
  assign sto_tvalid = sto_tvalid_q;
  assign sto_tdata = sto_tdata_q;
  assign sto_tid = sto_tid_q;
endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter: directed checks of the stream arbiter (BURST=4 and BURST=1 instances)
module tb_stream_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] ena, sti_tvalid, sti_tready, sti_tready1;
  logic [127:0] sti_tdata;
  logic sto_tready, sto_tvalid, sto_tvalid1;
  logic [31:0] sto_tdata, sto_tdata1;
  logic [1:0] sto_tid, sto_tid1;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  stream_arbiter #(.SDW(32), .NCH(4), .BURST(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sti_tdata(sti_tdata), .sto_tready(sto_tready), .sto_tvalid(sto_tvalid),
    .sto_tdata(sto_tdata), .sto_tid(sto_tid)
  );
  stream_arbiter #(.SDW(32), .NCH(4), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready1),
    .sti_tdata(sti_tdata), .sto_tready(sto_tready), .sto_tvalid(sto_tvalid1),
    .sto_tdata(sto_tdata1), .sto_tid(sto_tid1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    sti_tvalid = '0;
    sto_tready = 1'b1;
    ena = 4'hF;
    tick;
    tick;
    rst = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0;
    ena = 4'hF;
    sti_tvalid = 4'hF;
    sto_tready = 1'b1;
    sti_tdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    #1;
    chk("rst_tvalid", 64'(sto_tvalid), 64'd0);
    chk("rst_tdata", 64'(sto_tdata), 64'd0);
    chk("rst_tid", 64'(sto_tid), 64'd0);
    chk("rst_tready", 64'(sti_tready), 64'd0);
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("rot_first_ready", 64'(sti_tready), 64'h1);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk("rot_tvalid", 64'(sto_tvalid), 64'd1);
      chk("rot_tid", 64'(sto_tid), 64'(((k - 1) / 4) % 4));
      chk("rot_tdata", 64'(sto_tdata), 64'(32'hD000_0000 + ((k - 1) / 4) % 4));
    end
    sti_tvalid = '0;
    tick;
    chk("rot_drain_tvalid", 64'(sto_tvalid), 64'd0);
    do_reset;
    sti_tvalid = 4'b0100;
    sti_tdata[64 +: 32] = 32'hA5A5_0001;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("ch2_tvalid", 64'(sto_tvalid), 64'd1);
      chk("ch2_tid", 64'(sto_tid), 64'd2);
      chk("ch2_tdata", 64'(sto_tdata), 64'(32'hA5A5_0000 + k));
      if (k == 4) chk("ch2_regrant_ready", 64'(sti_tready), 64'b0100);
      sti_tdata[64 +: 32] = 32'hA5A5_0000 + 32'(k + 1);
    end
    do_reset;
    sti_tvalid = 4'b1010;
    sti_tdata[32 +: 32] = 32'h0000_1001;
    sti_tdata[96 +: 32] = 32'h3333_3333;
    tick;
    chk("bp_tid1", 64'(sto_tid), 64'd1);
    chk("bp_data1", 64'(sto_tdata), 64'h1001);
    sti_tdata[32 +: 32] = 32'h0000_1002;
    tick;
    chk("bp_data2", 64'(sto_tdata), 64'h1002);
    chk("bp_cnt2", 64'(dut.cnt_q), 64'd2);
    sti_tdata[32 +: 32] = 32'h0000_1003;
    sto_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_hold_tvalid", 64'(sto_tvalid), 64'd1);
      chk("bp_hold_tdata", 64'(sto_tdata), 64'h1002);
      chk("bp_hold_tid", 64'(sto_tid), 64'd1);
      chk("bp_hold_cnt", 64'(dut.cnt_q), 64'd2);
      chk("bp_hold_ready", 64'(sti_tready), 64'd0);
    end
    sto_tready = 1'b1;
    tick;
    chk("bp_data3", 64'(sto_tdata), 64'h1003);
    chk("bp_tid3", 64'(sto_tid), 64'd1);
    sti_tdata[32 +: 32] = 32'h0000_1004;
    tick;
    chk("bp_data4", 64'(sto_tdata), 64'h1004);
    chk("bp_tid4", 64'(sto_tid), 64'd1);
    tick;
    chk("bp_next_tid", 64'(sto_tid), 64'd3);
    chk("bp_next_data", 64'(sto_tdata), 64'h3333_3333);
    do_reset;
    sti_tvalid = 4'b1001;
    sti_tdata[0 +: 32] = 32'h0000_0A0A;
    sti_tdata[96 +: 32] = 32'h3333_0003;
    tick;
    chk("ena_tid0", 64'(sto_tid), 64'd0);
    chk("ena_data0", 64'(sto_tdata), 64'h0A0A);
    ena = 4'b1110;
    #1;
    chk("ena_drop_ready", 64'(sti_tready), 64'd0);
    tick;
    chk("ena_gap_tvalid", 64'(sto_tvalid), 64'd0);
    chk("ena_gap_tid", 64'(sto_tid), 64'd0);
    chk("ena_ptr", 64'(dut.ptr_q), 64'd1);
    chk("ena_ch3_ready", 64'(sti_tready), 64'b1000);
    tick;
    chk("ena_ch3_tid", 64'(sto_tid), 64'd3);
    chk("ena_ch3_tvalid", 64'(sto_tvalid), 64'd1);
    chk("ena_ch3_data", 64'(sto_tdata), 64'h3333_0003);
    do_reset;
    sti_tvalid = 4'b0100;
    tick;
    chk("ar_pre_tvalid", 64'(sto_tvalid), 64'd1);
    chk("ar_pre_tid", 64'(sto_tid), 64'd2);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_tvalid", 64'(sto_tvalid), 64'd0);
    chk("ar_tdata", 64'(sto_tdata), 64'd0);
    chk("ar_tid", 64'(sto_tid), 64'd0);
    chk("ar_ready", 64'(sti_tready), 64'd0);
    sti_tvalid = 4'b0110;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_restart_ready", 64'(sti_tready), 64'b0010);
    tick;
    chk("ar_restart_tid", 64'(sto_tid), 64'd1);
    chk("ar_restart_tvalid", 64'(sto_tvalid), 64'd1);
    do_reset;
    sti_tvalid = 4'b0011;
    sti_tdata[0 +: 32] = 32'hB000_0000;
    sti_tdata[32 +: 32] = 32'hB000_0001;
    for (int k = 1; k <= 6; k++) begin
      tick;
      chk("b1_tvalid", 64'(sto_tvalid1), 64'd1);
      chk("b1_tid", 64'(sto_tid1), 64'((k - 1) % 2));
      chk("b1_tdata", 64'(sto_tdata1), 64'(32'hB000_0000 + (k - 1) % 2));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
